ir_packet_scheduler: RTL and testbench

IR_PACKET_SCHEDULER -- requirements
Module: ir_packet_scheduler

---
 rtl/ir_pkg.sv | 23 ++
 rtl/ir_period_timer.sv | 45 ++++
 rtl/ir_packet_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_ir_packet_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared command encodings, register offsets and FSM state type
//
// Purpose: definitions shared by ir_packet_scheduler and its sub-modules.
// Ports:   none (package).
package ir_pkg;

  // Command codes, one-hot per direction; other codes are passed through as-is.
  localparam logic [3:0] CMD_RIGHT = 4'b0001;
  localparam logic [3:0] CMD_LEFT  = 4'b0010;
  localparam logic [3:0] CMD_BACK  = 4'b0100;
  localparam logic [3:0] CMD_FWD   = 4'b1000;

  // Register offsets relative to BASE_ADDR.
  localparam logic [7:0] CMD_REG_OFS  = 8'd0;
  localparam logic [7:0] CTRL_REG_OFS = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } ir_state_e;

endpackage

// File: rtl/ir_period_timer.sv
// rtl/ir_period_timer.sv - terminal-count period counter with clear and enable
//
// Purpose: counts 0..TERM_COUNT-1 and wraps while enabled; held at 0 while cleared.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - synchronous clear (forces count to 0)
//   en_i   - count enable
//   tc_o   - terminal count flag, high while enabled and count == TERM_COUNT-1
module ir_period_timer #(
  parameter int TERM_COUNT = 100,
  parameter int CNT_W      = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM_COUNT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/ir_packet_scheduler.sv
// rtl/ir_packet_scheduler.sv - bus-programmed scheduler for periodic IR packet windows
//
// Purpose: holds a command register and an enable bit written over a simple bus,
// and every PERIOD_CYCLES opens a SEND_PACKET window of SEND_CYCLES cycles while
// presenting the latched command on COMMAND.
// Optional feature: define IR_SCHED_WDOG_EN to clear the command register after
// WDOG_PACKETS completed packets with no command write.
// Ports:
//   CLK         - system clock
//   RESET       - synchronous active-high reset
//   BUS_ADDR    - bus address (BASE_ADDR: command, BASE_ADDR+1: control)
//   BUS_DATA    - bus write data
//   BUS_WE      - one-cycle write strobe
//   COMMAND     - {fwd,back,left,right} command to the transmitter
//   SEND_PACKET - packet window level
//   BUSY        - copy of SEND_PACKET
module ir_packet_scheduler
  import ir_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = 8'h90,
  parameter int         PERIOD_CYCLES = 10_000_000,
  parameter int         SEND_CYCLES   = 4_000_000,
  parameter int         WDOG_PACKETS  = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET,
  output logic       BUSY
);

  if (!(SEND_CYCLES > 0 && SEND_CYCLES < PERIOD_CYCLES)) begin : g_bad_window
    $error("ir_packet_scheduler: need 0 < SEND_CYCLES < PERIOD_CYCLES");
  end

  // A zero watchdog limit would clear the command before any packet completes.
  if (WDOG_PACKETS < 1) begin : g_bad_wdog
    $error("ir_packet_scheduler: WDOG_PACKETS must be at least 1");
  end

  localparam int         PERIOD_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int         SEND_W   = (SEND_CYCLES > 1) ? $clog2(SEND_CYCLES) : 1;
  localparam logic [SEND_W-1:0] SEND_LAST = SEND_W'(SEND_CYCLES - 1);
  localparam logic [7:0] CMD_ADDR  = BASE_ADDR + CMD_REG_OFS;
  localparam logic [7:0] CTRL_ADDR = BASE_ADDR + CTRL_REG_OFS;

  logic        cmd_we;
  logic        ctrl_we;
  logic [3:0]  cmd_q;
  logic [3:0]  cmd_d;
  logic        enable_q;
  logic        enable_d;
  logic        tick;
  logic        send_done;
  logic        wdog_fire;
  logic        unused_data;

  ir_state_e   state_q;
  logic [3:0]  command_q;
  logic        send_q;
  logic [SEND_W-1:0] send_cnt_q;

  assign cmd_we      = BUS_WE && (BUS_ADDR == CMD_ADDR);
  assign ctrl_we     = BUS_WE && (BUS_ADDR == CTRL_ADDR);
  assign unused_data = ^BUS_DATA[7:4];

  // Register next-state. The same cmd_d feeds COMMAND at packet start, so a
  // write landing on the tick cycle is forwarded into that packet.
  always_comb begin
    cmd_d    = cmd_q;
    enable_d = enable_q;
    if (cmd_we) begin
      cmd_d = BUS_DATA[3:0];
    end else if (wdog_fire) begin
      cmd_d = 4'b0000;
    end
    if (ctrl_we) begin
      enable_d = BUS_DATA[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_q    <= 4'b0000;
      enable_q <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      enable_q <= enable_d;
    end
  end

  // Period counter runs only while enabled, so the first tick lands
  // PERIOD_CYCLES edges after the enable write.
  ir_period_timer #(
    .TERM_COUNT (PERIOD_CYCLES),
    .CNT_W      (PERIOD_W)
  ) u_timer (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (!enable_q),
    .en_i  (enable_q),
    .tc_o  (tick)
  );

  assign send_done = (send_cnt_q == SEND_LAST);

`ifdef IR_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_PACKETS + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_PACKETS - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_PACKETS);

  logic              pkt_done;
  logic [WDOG_W-1:0] pkt_cnt_q;

  assign pkt_done  = (state_q == ST_SEND) && send_done;
  assign wdog_fire = pkt_done && (pkt_cnt_q == WDOG_LAST);

  // Saturates at the limit so the clear fires once per silent stretch.
  always_ff @(posedge CLK) begin
    if (RESET || cmd_we) begin
      pkt_cnt_q <= '0;
    end else if (pkt_done && (pkt_cnt_q != WDOG_MAX)) begin
      pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  // Packet FSM with registered COMMAND / SEND_PACKET. Clearing enable in SEND
  // does not cut the window short; only RESET does.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      command_q  <= 4'b0000;
      send_q     <= 1'b0;
      send_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_q) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!enable_q) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            state_q    <= ST_SEND;
            command_q  <= cmd_d;
            send_q     <= 1'b1;
            send_cnt_q <= '0;
          end
        end
        ST_SEND: begin
          if (send_done) begin
            state_q    <= enable_q ? ST_WAIT : ST_IDLE;
            send_q     <= 1'b0;
            send_cnt_q <= '0;
          end else begin
            send_cnt_q <= send_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          send_q     <= 1'b0;
          send_cnt_q <= '0;
        end
      endcase
    end
  end

  assign COMMAND     = command_q;
  assign SEND_PACKET = send_q;
  assign BUSY        = send_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// tb/tb_ir_packet_scheduler.sv - directed self-checking bench for ir_packet_scheduler
module tb_ir_packet_scheduler;
  import ir_pkg::*;

  logic       CLK;
  logic       RESET;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;
  logic       BUS_WE;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic       BUSY;

  int checks_total;
  int checks_passed;

  ir_packet_scheduler #(
    .BASE_ADDR     (8'h90),
    .PERIOD_CYCLES (100),
    .SEND_CYCLES   (30),
    .WDOG_PACKETS  (3)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_DATA    (BUS_DATA),
    .BUS_WE      (BUS_WE),
    .COMMAND     (COMMAND),
    .SEND_PACKET (SEND_PACKET),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive one write; returns 1 time unit after the edge that captured it.
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a;
    BUS_DATA = d;
    BUS_WE   = 1'b1;
    wait_edges(1);
    BUS_WE   = 1'b0;
  endtask

  task automatic watch_quiet(input int n, input string tag);
    int hi;
    hi = 0;
    repeat (n) begin
      wait_edges(1);
      if (SEND_PACKET) hi++;
    end
    chk(tag, 32'(hi), 32'd0);
  endtask

  initial begin
    logic [3:0] wdog_exp;
    checks_total  = 0;
    checks_passed = 0;
    RESET    = 1'b1;
    BUS_WE   = 1'b0;
    BUS_ADDR = 8'h00;
    BUS_DATA = 8'h00;
    wait_edges(2);

    // Writes during reset must be dropped.
    BUS_ADDR = 8'h91; BUS_DATA = 8'h01; BUS_WE = 1'b1;
    wait_edges(1);
    BUS_ADDR = 8'h90; BUS_DATA = 8'h08;
    wait_edges(1);
    BUS_WE = 1'b0;
    chk("rst_send",  32'(SEND_PACKET), 32'd0);
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_cmd",   32'(COMMAND), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_timer", 32'(dut.u_timer.count_q), 32'd0);
    RESET = 1'b0;
    watch_quiet(150, "rst_overrides_write");

    // Other addresses and enable bit 0 clear must not start packets.
    bus_wr(8'h92, 8'h01);
    bus_wr(8'h8F, 8'h01);
    bus_wr(8'h91, 8'h02);
    watch_quiet(150, "other_addr_ignored");

    // Enable at E0, command FWD at E1: first rise at E100.
    bus_wr(8'h91, 8'h01);
    bus_wr(8'h90, 8'h08);
    wait_edges(98);
    chk("pre_first_rise", 32'(SEND_PACKET), 32'd0);
    wait_edges(1);
    chk("first_rise", 32'(SEND_PACKET), 32'd1);
    chk("first_cmd", 32'(COMMAND), 32'(CMD_FWD));
    chk("first_busy", 32'(BUSY), 32'd1);
    bus_wr(8'h90, 8'h01);
    chk("cmd_held_in_send", 32'(COMMAND), 32'(CMD_FWD));
    wait_edges(28);
    chk("window_last", 32'(SEND_PACKET), 32'd1);
    wait_edges(1);
    chk("window_end", 32'(SEND_PACKET), 32'd0);
    chk("cmd_held_after", 32'(COMMAND), 32'(CMD_FWD));
    wait_edges(69);
    chk("pre_second_rise", 32'(SEND_PACKET), 32'd0);
    wait_edges(1);
    chk("second_rise", 32'(SEND_PACKET), 32'd1);
    chk("second_cmd", 32'(COMMAND), 32'(CMD_RIGHT));

    // Write lands on the tick cycle (E299->E300): forwarded into this packet.
    wait_edges(99);
    chk("pre_third_rise", 32'(SEND_PACKET), 32'd0);
    bus_wr(8'h90, 8'hF5);
    chk("third_rise", 32'(SEND_PACKET), 32'd1);
    chk("tick_forward_cmd", 32'(COMMAND), 32'h5);

    // Disable 10 cycles into the window: window still completes.
    wait_edges(9);
    bus_wr(8'h91, 8'h00);
    wait_edges(19);
    chk("disable_window_last", 32'(SEND_PACKET), 32'd1);
    wait_edges(1);
    chk("disable_window_end", 32'(SEND_PACKET), 32'd0);
    chk("disable_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("disable_timer", 32'(dut.u_timer.count_q), 32'd0);
    watch_quiet(250, "no_packets_disabled");

    // Reset in the middle of a window.
    bus_wr(8'h91, 8'h01);
    wait_edges(99);
    chk("pre_reset_rise", 32'(SEND_PACKET), 32'd0);
    wait_edges(1);
    chk("pre_reset_send", 32'(SEND_PACKET), 32'd1);
    chk("pre_reset_cmd", 32'(COMMAND), 32'h5);
    wait_edges(5);
    RESET = 1'b1;
    wait_edges(1);
    chk("mid_rst_send", 32'(SEND_PACKET), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_cmd", 32'(COMMAND), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    RESET = 1'b0;
    wait_edges(1);

    // Watchdog: command written once, then four packets.
`ifdef IR_SCHED_WDOG_EN
    wdog_exp = 4'b0000;
`else
    wdog_exp = CMD_FWD;
`endif
    bus_wr(8'h91, 8'h01);
    bus_wr(8'h90, 8'h08);
    wait_edges(99);
    chk("wdog_pkt1_send", 32'(SEND_PACKET), 32'd1);
    chk("wdog_pkt1_cmd", 32'(COMMAND), 32'(CMD_FWD));
    wait_edges(200);
    chk("wdog_pkt3_send", 32'(SEND_PACKET), 32'd1);
    chk("wdog_pkt3_cmd", 32'(COMMAND), 32'(CMD_FWD));
    wait_edges(100);
    chk("wdog_pkt4_send", 32'(SEND_PACKET), 32'd1);
    chk("wdog_pkt4_cmd", 32'(COMMAND), 32'(wdog_exp));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
